wddl_xor_pipe: RTL and testbench
================================

WDDL_XOR_PIPE -- requirements
Module: wddl_xor_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of dual-rail bit pairs per operand (legal 1..64).
REQ-002 SHALL provide parameter STAGES, default 2: number of pipeline register stages (legal 1..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ld  input  1  operand pair is presented this cycle.
REQ-006 d0_p_in  input  WIDTH  operand 0 true rail.
REQ-007 d0_n_in  input  WIDTH  operand 0 false rail.
REQ-008 d1_p_in  input  WIDTH  operand 1 true rail.
REQ-009 d1_n_in  input  WIDTH  operand 1 false rail.
REQ-010 phase  output  1  current phase: 0 = precharge, 1 = evaluate.
REQ-011 d_p_out  output  WIDTH  XOR result true rail.
REQ-012 d_n_out  output  WIDTH  XOR result false rail.
REQ-013 done  output  1  d_p_out/d_n_out hold a valid codeword this cycle.
REQ-014 rail_err  output  1  sticky rail-violation flag.

Function
REQ-015 The phase register SHALL toggle every cycle when out of reset, starting at 0 in the first cycle after reset release.
REQ-016 ld SHALL be accepted only when ld=1 and phase=1; ld while phase=0 SHALL be ignored with no state change other than the phase toggle.
REQ-017 On acceptance, stage 0 SHALL capture p = (d0_n&d1_p)|(d0_p&d1_n) and n = (d0_p|d1_n)&(d0_n|d1_p), both bitwise, plus valid=1.
REQ-018 When there is no acceptance, stage 0 SHALL capture the spacer p=0, n=0 and valid=0.
REQ-019 Stage k (k>=1) SHALL capture stage k-1 every cycle unconditionally, with no stall or back-pressure.
REQ-020 d_p_out, d_n_out and done SHALL be driven directly from the last stage. Latency from the accepting edge to done=1 is exactly STAGES cycles.
REQ-021 A valid token and a spacer SHALL each occupy exactly one cycle at the output, so valid tokens are always separated by at least one spacer cycle.
REQ-022 If ld is held high continuously, done SHALL follow a 1,0,1,0 pattern once the pipeline fills.
REQ-023 When done=0, outputs SHALL be 0 on both rails. When done=1 and the inputs were complementary, d_n_out SHALL equal ~d_p_out.
REQ-024 No output SHALL depend combinationally on any input.

Reset
REQ-025 While rst=1, phase, all stage rails, all valid bits and rail_err SHALL be 0 immediately, independent of clk.
REQ-026 Reset asserted with tokens in flight SHALL discard them; no done pulse for them may appear after release.
REQ-027 After release, the first acceptance SHALL be possible in the second cycle, when phase=1.

Configuration
REQ-028 With macro WDDL_RAIL_CHECK_EN defined, on each accepted cycle the block SHALL check every bit with d0_p_in==d0_n_in or d1_p_in==d1_n_in. Any violation SHALL set rail_err on the next edge; rail_err then holds until rst.
REQ-029 With WDDL_RAIL_CHECK_EN defined, violations on non-accepted cycles SHALL NOT set rail_err.
REQ-030 Without WDDL_RAIL_CHECK_EN, rail_err SHALL be tied to 0 and no check logic is generated. All other behaviour is identical and the port list is unchanged.
REQ-031 The data path SHALL be identical with or without the macro. A violating operand still propagates as computed by REQ-017.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-032 Reset release, then in the phase=1 cycle drive ld=1, d0_p=0xA5/d0_n=0x5A, d1_p=0x3C/d1_n=0xC3 -> 2 cycles later d_p_out=0x99, d_n_out=0x66, done=1; the next cycle gives 0x00/0x00, done=0.
REQ-033 Drive ld=1 with the same operands only in a phase=0 cycle -> outputs stay 0x00/0x00, done=0 for 5 cycles.
REQ-034 Hold ld=1 for 10 cycles with d1 constant and d0 incrementing -> done toggles 1,0,1,... and each valid output equals d0 XOR d1 of the accepted cycle.
REQ-035 Accept with d0_p=d0_n=0x01 -> with WDDL_RAIL_CHECK_EN, rail_err=1 from the next cycle and stays 1 through 20 clean operations until rst. Without the macro, rail_err stays 0.
REQ-036 Assert rst asynchronously between clock edges while 2 tokens are in flight -> outputs 0x00/0x00, done=0, phase=0 before the next edge. After release, no stale done appears.
REQ-037 With STAGES=1, WIDTH=1, accept d0=1, d1=1 -> next cycle d_p_out=0, d_n_out=1, done=1.

Source files
------------

// File: rtl/wddl_xor_pipe.sv
// Dual-rail (WDDL) XOR with a precharge/evaluate phase and a STAGES-deep spacer-separated pipeline.
// Optional rail-violation checker enabled by defining WDDL_RAIL_CHECK_EN.
module wddl_xor_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d0_p_in,
  input  logic [WIDTH-1:0] d0_n_in,
  input  logic [WIDTH-1:0] d1_p_in,
  input  logic [WIDTH-1:0] d1_n_in,
  output logic             phase,
  output logic [WIDTH-1:0] d_p_out,
  output logic [WIDTH-1:0] d_n_out,
  output logic             done,
  output logic             rail_err
);

  logic             r_phase;
  logic [WIDTH-1:0] r_p [STAGES];
  logic [WIDTH-1:0] r_n [STAGES];
  logic [STAGES-1:0] r_vld;

  logic             w_acc;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_n;

  // Operands are only sampled in the evaluate phase; everything else becomes a spacer.
  assign w_acc = ld & r_phase;
  assign w_p   = (d0_n_in & d1_p_in) | (d0_p_in & d1_n_in);
  assign w_n   = (d0_p_in | d1_n_in) & (d0_n_in | d1_p_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_vld   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_p[k] <= '0;
        r_n[k] <= '0;
      end
    end else begin
      r_phase  <= ~r_phase;
      r_vld[0] <= w_acc;
      r_p[0]   <= w_acc ? w_p : '0;
      r_n[0]   <= w_acc ? w_n : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_p[k]   <= r_p[k-1];
        r_n[k]   <= r_n[k-1];
      end
    end
  end

  assign phase   = r_phase;
  assign d_p_out = r_p[STAGES-1];
  assign d_n_out = r_n[STAGES-1];
  assign done    = r_vld[STAGES-1];

`ifdef WDDL_RAIL_CHECK_EN
  logic r_rail_err;
  logic w_viol;

  // A pair with equal rails is not a legal codeword (neither 01 nor 10).
  assign w_viol = |((d0_p_in ~^ d0_n_in) | (d1_p_in ~^ d1_n_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rail_err <= 1'b0;
    end else if (w_acc && w_viol) begin
      r_rail_err <= 1'b1;
    end
  end

  assign rail_err = r_rail_err;
`else
  assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_xor_pipe.sv
// Directed bench for wddl_xor_pipe: table-driven vectors plus hand-written reset/rail/STAGES=1 cases.
module tb_wddl_xor_pipe;

`ifdef WDDL_RAIL_CHECK_EN
  localparam logic EXP_RAIL = 1'b1;
`else
  localparam logic EXP_RAIL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [7:0] d0_p = '0, d0_n = '0, d1_p = '0, d1_n = '0;
  logic       phase, done, rail_err;
  logic [7:0] d_p, d_n;

  logic       ld2 = 1'b0;
  logic [0:0] e0_p = '0, e0_n = '0, e1_p = '0, e1_n = '0;
  logic       phase2, done2, rail_err2;
  logic [0:0] e_p, e_n;

  int n_chk  = 0;
  int n_pass = 0;

  wddl_xor_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .ld(ld),
    .d0_p_in(d0_p), .d0_n_in(d0_n), .d1_p_in(d1_p), .d1_n_in(d1_n),
    .phase(phase), .d_p_out(d_p), .d_n_out(d_n), .done(done), .rail_err(rail_err)
  );

  wddl_xor_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .ld(ld2),
    .d0_p_in(e0_p), .d0_n_in(e0_n), .d1_p_in(e1_p), .d1_n_in(e1_n),
    .phase(phase2), .d_p_out(e_p), .d_n_out(e_n), .done(done2), .rail_err(rail_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] d0p, d0n, d1p, d1n;
    logic       ephase;
    logic       edone;
    logic [7:0] ep, en;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic l, input logic [7:0] a_p, input logic [7:0] a_n,
                       input logic [7:0] b_p, input logic [7:0] b_n);
    ld = l; d0_p = a_p; d0_n = a_n; d1_p = b_p; d1_n = b_n;
  endtask

  task automatic chk_out(input string tag, input logic eph, input logic edn,
                         input logic [7:0] ep, input logic [7:0] en);
    chk({tag, ".phase"}, 64'(phase), 64'(eph));
    chk({tag, ".done"},  64'(done),  64'(edn));
    chk({tag, ".p"},     64'(d_p),   64'(ep));
    chk({tag, ".n"},     64'(d_n),   64'(en));
  endtask

  initial begin
    logic [7:0] xv;

    // Cycle 0 after release is phase 0 (ignored ld), cycle 1 is the first acceptance.
    tbl[0]  = '{1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 8'h66};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 8'hFF, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hF0, 8'h0F};
    tbl[11] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};

    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 8'h00, 8'h00);
    chk("reset.rail_err", 64'(rail_err), 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ld, tbl[i].d0p, tbl[i].d0n, tbl[i].d1p, tbl[i].d1n);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].ephase, tbl[i].edone, tbl[i].ep, tbl[i].en);
    end

    // ld held high for 10 cycles: only phase-1 cycles (odd j) accept.
    for (int j = 0; j < 12; j++) begin
      xv = 8'(8'h10 + j);
      drive(j < 10, xv, ~xv, 8'h3C, 8'hC3);
      tick();
      xv = 8'(8'h10 + j - 1) ^ 8'h3C;
      if (j >= 2 && (j % 2) == 0)
        chk_out($sformatf("stream%0d", j), 1'b1, 1'b1, xv, ~xv);
      else
        chk_out($sformatf("stream%0d", j), (j % 2) == 0, 1'b0, 8'h00, 8'h00);
    end

    // Violating operand in a phase-0 cycle must not flag; accepted one must.
    drive(1'b1, 8'h01, 8'h01, 8'h3C, 8'hC3);
    tick();
    chk("rail.ignored", 64'(rail_err), 64'd0);
    chk("rail.phase", 64'(phase), 64'd1);
    tick();
    chk("rail.set", 64'(rail_err), 64'(EXP_RAIL));
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_out("rail.data", 1'b1, 1'b1, 8'h01, 8'h01);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i), ~8'(i), 8'h3C, 8'hC3);
      tick();
      chk($sformatf("rail.hold%0d", i), 64'(rail_err), 64'(EXP_RAIL));
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    if (phase !== 1'b1) tick();

    // Async reset with token X at the output and token Y being presented.
    drive(1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_out("inflight", 1'b1, 1'b1, 8'h99, 8'h66);
    drive(1'b1, 8'hFF, 8'h00, 8'h0F, 8'hF0);
    #2 rst = 1'b1;
    #1 chk_out("async1", 1'b0, 1'b0, 8'h00, 8'h00);
    chk("async1.rail_err", 64'(rail_err), 64'd0);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #2 rst = 1'b0;
    tick();
    chk("async1.phase_rel", 64'(phase), 64'd1);

    // Token Y sitting in stage 0 when reset hits mid-cycle must never surface.
    drive(1'b1, 8'hFF, 8'h00, 8'h0F, 8'hF0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #2 rst = 1'b1;
    #1 chk_out("async2", 1'b0, 1'b0, 8'h00, 8'h00);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("stale%0d.done", i), 64'(done), 64'd0);
      chk($sformatf("stale%0d.p", i), 64'(d_p), 64'd0);
    end

    // WIDTH=1, STAGES=1 instance shares clock and reset.
    if (phase2 !== 1'b1) tick();
    chk("s1.phase", 64'(phase2), 64'd1);
    ld2 = 1'b1; e0_p = 1'b1; e0_n = 1'b0; e1_p = 1'b1; e1_n = 1'b0;
    tick();
    chk("s1.done", 64'(done2), 64'd1);
    chk("s1.p", 64'(e_p), 64'd0);
    chk("s1.n", 64'(e_n), 64'd1);
    ld2 = 1'b0; e0_p = 1'b0; e1_p = 1'b0;
    tick();
    chk("s1.spacer_done", 64'(done2), 64'd0);
    chk("s1.spacer_n", 64'(e_n), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
